// File: rtl/cp0_regfile.sv
// CP0 register file: BadVAddr, Count, Compare, Status, Cause and EPC with
// exception/ERET/MTC0 commit handling, timer interrupt and interrupt request.
module cp0_regfile (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_ex,
  input  logic [4:0]  wb_excode,
  input  logic [31:0] wb_badvaddr,
  input  logic        wb_bd,
  input  logic [31:0] wb_pc,
  input  logic        mtc0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] mtc0_wdata,
  input  logic        eret_flush,
  input  logic [5:0]  ext_int_in,
  output logic [31:0] cp0_rdata,
  output logic        has_int,
  output logic [31:0] cp0_epc
);

  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_COUNT    = 5'd9;
  localparam logic [4:0] ADDR_COMPARE  = 5'd11;
  localparam logic [4:0] ADDR_STATUS   = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;

  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;

  // Status fields
  logic [7:0]  status_im;
  logic        status_exl;
  logic        status_ie;

  // Cause fields
  logic        cause_bd;
  logic        cause_ti;
  logic [5:0]  cause_ip_hw;
  logic [1:0]  cause_ip_sw;
  logic [4:0]  cause_exccode;

  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic [31:0] epc_q;
  logic [31:0] badvaddr_q;
  logic        tick_q;

  logic        eret_en;
  logic        mtc0_en;
  logic        wr_count;
  logic        wr_compare;
  logic        wr_status;
  logic        wr_cause;
  logic        wr_epc;
  logic        timer_hit;
  logic        ti_next;
  logic [31:0] status_rd;
  logic [31:0] cause_rd;

  // Commit priority: exception, then ERET, then MTC0
  assign eret_en    = eret_flush & ~wb_ex;
  assign mtc0_en    = mtc0_we & ~wb_ex & ~eret_flush;
  assign wr_count   = mtc0_en && (cp0_addr == ADDR_COUNT);
  assign wr_compare = mtc0_en && (cp0_addr == ADDR_COMPARE);
  assign wr_status  = mtc0_en && (cp0_addr == ADDR_STATUS);
  assign wr_cause   = mtc0_en && (cp0_addr == ADDR_CAUSE);
  assign wr_epc     = mtc0_en && (cp0_addr == ADDR_EPC);

  // Timer interrupt fires on entry into Count==Compare; a Compare write clears it
  assign timer_hit = tick_q && ((count_q + 32'd1) == compare_q);

  always_comb begin
    ti_next = cause_ti;
    if (timer_hit) begin
      ti_next = 1'b1;
    end
    if (wr_compare) begin
      ti_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tick_q  <= 1'b0;
      count_q <= 32'd0;
    end else begin
      tick_q <= ~tick_q;
      if (wr_count) begin
        count_q <= mtc0_wdata;
      end else if (tick_q) begin
        count_q <= count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      compare_q <= 32'd0;
    end else if (wr_compare) begin
      compare_q <= mtc0_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      status_im  <= 8'd0;
      status_exl <= 1'b0;
      status_ie  <= 1'b0;
    end else if (wb_ex) begin
      status_exl <= 1'b1;
    end else if (eret_en) begin
      status_exl <= 1'b0;
    end else if (wr_status) begin
      status_im  <= mtc0_wdata[15:8];
      status_exl <= mtc0_wdata[1];
      status_ie  <= mtc0_wdata[0];
    end
  end

  // Hardware IP lines follow ext_int_in every cycle, with TI merged into IP7
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cause_bd      <= 1'b0;
      cause_ti      <= 1'b0;
      cause_ip_hw   <= 6'd0;
      cause_ip_sw   <= 2'd0;
      cause_exccode <= 5'd0;
    end else begin
      cause_ti    <= ti_next;
      cause_ip_hw <= {ext_int_in[5] | ti_next, ext_int_in[4:0]};
      if (wb_ex) begin
        cause_exccode <= wb_excode;
        if (!status_exl) begin
          cause_bd <= wb_bd;
        end
      end else if (wr_cause) begin
        cause_ip_sw <= mtc0_wdata[9:8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      epc_q <= 32'd0;
    end else if (wb_ex) begin
      if (!status_exl) begin
        epc_q <= wb_bd ? (wb_pc - 32'd4) : wb_pc;
      end
    end else if (wr_epc) begin
      epc_q <= mtc0_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      badvaddr_q <= 32'd0;
    end else if (wb_ex && ((wb_excode == EXC_ADEL) || (wb_excode == EXC_ADES))) begin
      badvaddr_q <= wb_badvaddr;
    end
  end

  assign status_rd = {9'd0, 1'b1, 6'd0, status_im, 6'd0, status_exl, status_ie};
  assign cause_rd  = {cause_bd, cause_ti, 14'd0, cause_ip_hw, cause_ip_sw,
                      1'b0, cause_exccode, 2'b00};

  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      ADDR_BADVADDR: cp0_rdata = badvaddr_q;
      ADDR_COUNT:    cp0_rdata = count_q;
      ADDR_COMPARE:  cp0_rdata = compare_q;
      ADDR_STATUS:   cp0_rdata = status_rd;
      ADDR_CAUSE:    cp0_rdata = cause_rd;
      ADDR_EPC:      cp0_rdata = epc_q;
      default:       cp0_rdata = 32'd0;
    endcase
  end

  assign has_int = (|({cause_ip_hw, cause_ip_sw} & status_im)) & status_ie & ~status_exl;
  assign cp0_epc = epc_q;

endmodule

// File: tb/tb_cp0_regfile.sv
// Scoreboard bench for cp0_regfile: randomized and directed commits checked
// against a whole-register reference model kept in the bench.
module tb_cp0_regfile;

  logic        clk;
  logic        resetn;
  logic        wb_ex;
  logic [4:0]  wb_excode;
  logic [31:0] wb_badvaddr;
  logic        wb_bd;
  logic [31:0] wb_pc;
  logic        mtc0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] mtc0_wdata;
  logic        eret_flush;
  logic [5:0]  ext_int_in;
  logic [31:0] cp0_rdata;
  logic        has_int;
  logic [31:0] cp0_epc;

  cp0_regfile dut (
    .clk         (clk),
    .resetn      (resetn),
    .wb_ex       (wb_ex),
    .wb_excode   (wb_excode),
    .wb_badvaddr (wb_badvaddr),
    .wb_bd       (wb_bd),
    .wb_pc       (wb_pc),
    .mtc0_we     (mtc0_we),
    .cp0_addr    (cp0_addr),
    .mtc0_wdata  (mtc0_wdata),
    .eret_flush  (eret_flush),
    .ext_int_in  (ext_int_in),
    .cp0_rdata   (cp0_rdata),
    .has_int     (has_int),
    .cp0_epc     (cp0_epc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] rd;
    logic        hi;
    logic [31:0] epc;
  } exp_t;

  exp_t  sb[$];
  string tag_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  // Reference model: architectural register images
  logic [31:0] m_status, m_cause, m_count, m_compare, m_epc, m_bad;
  logic        m_tick;

  logic [4:0] impl_addr [6] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14};

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_bad;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_has_int();
    return (|(m_cause[15:8] & m_status[15:8])) & m_status[0] & ~m_status[1];
  endfunction

  task automatic model_step();
    logic [31:0] s, c, cnt, cmp, epc, bad;
    logic        ti;
    if (!resetn) begin
      m_status = 32'h0040_0000; m_cause = 32'h0; m_count = 32'h0;
      m_compare = 32'h0; m_epc = 32'h0; m_bad = 32'h0; m_tick = 1'b0;
      return;
    end
    s = m_status; c = m_cause; cnt = m_count; cmp = m_compare;
    epc = m_epc; bad = m_bad; ti = m_cause[30];
    if (m_tick && (m_count + 32'd1 == m_compare)) ti = 1'b1;
    if (m_tick) cnt = m_count + 32'd1;
    if (wb_ex) begin
      if (!m_status[1]) begin
        epc   = wb_bd ? wb_pc - 32'd4 : wb_pc;
        c[31] = wb_bd;
      end
      s[1]   = 1'b1;
      c[6:2] = wb_excode;
      if (wb_excode == 5'h04 || wb_excode == 5'h05) bad = wb_badvaddr;
    end else if (eret_flush) begin
      s[1] = 1'b0;
    end else if (mtc0_we) begin
      case (cp0_addr)
        5'd9:    cnt = mtc0_wdata;
        5'd11:   begin cmp = mtc0_wdata; ti = 1'b0; end
        5'd12:   s = (mtc0_wdata & 32'h0000_FF03) | 32'h0040_0000;
        5'd13:   c[9:8] = mtc0_wdata[9:8];
        5'd14:   epc = mtc0_wdata;
        default: ;
      endcase
    end
    c[30]    = ti;
    c[15:10] = {ext_int_in[5] | ti, ext_int_in[4:0]};
    m_status = s; m_cause = c; m_count = cnt; m_compare = cmp;
    m_epc = epc; m_bad = bad; m_tick = ~m_tick;
  endtask

  task automatic clr();
    wb_ex = 1'b0; wb_excode = 5'd0; wb_badvaddr = 32'd0; wb_bd = 1'b0;
    wb_pc = 32'd0; mtc0_we = 1'b0; mtc0_wdata = 32'd0; eret_flush = 1'b0;
  endtask

  // Push the expected view of the current cycle, then commit one clock edge
  task automatic step(input string tag, input logic [31:0] want_rd, input bit use_rd,
                      input logic want_int, input bit use_int);
    exp_t e;
    e.addr = cp0_addr;
    e.rd   = use_rd  ? want_rd  : m_read(cp0_addr);
    e.hi   = use_int ? want_int : m_has_int();
    e.epc  = m_epc;
    sb.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic mtc0(input string tag, input logic [4:0] a, input logic [31:0] d);
    clr(); mtc0_we = 1'b1; cp0_addr = a; mtc0_wdata = d;
    step(tag, 32'h0, 0, 1'b0, 0);
    clr();
  endtask

  task automatic rd(input string tag, input logic [4:0] a);
    clr(); cp0_addr = a;
    step(tag, 32'h0, 0, 1'b0, 0);
  endtask

  task automatic rd_want(input string tag, input logic [4:0] a, input logic [31:0] w);
    clr(); cp0_addr = a;
    step(tag, w, 1, 1'b0, 0);
  endtask

  // Monitor: compare every presented cycle against the queued expectation
  exp_t  me;
  string mt;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      me = sb.pop_front();
      mt = tag_q.pop_front();
      n_cmp++;
      if (cp0_rdata !== me.rd) begin
        n_bad++;
        $display("FAIL %s cp0_rdata addr=%0d got=%h want=%h", mt, me.addr, cp0_rdata, me.rd);
      end
      n_cmp++;
      if (has_int !== me.hi) begin
        n_bad++;
        $display("FAIL %s has_int got=%b want=%b", mt, has_int, me.hi);
      end
      n_cmp++;
      if (cp0_epc !== me.epc) begin
        n_bad++;
        $display("FAIL %s cp0_epc got=%h want=%h", mt, cp0_epc, me.epc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    resetn = 1'b0; cp0_addr = 5'd0; ext_int_in = 6'd0;
    @(posedge clk);
    model_step();
    #1;

    // Reset state, including requests that reset must override
    cp0_addr = 5'd12;
    step("rst_status", 32'h0040_0000, 1, 1'b0, 1);
    wb_ex = 1'b1; wb_pc = 32'h1111_0000; eret_flush = 1'b1;
    mtc0_we = 1'b1; cp0_addr = 5'd14; mtc0_wdata = 32'hDEAD_BEEF; ext_int_in = 6'h3F;
    step("rst_override", 32'h0, 1, 1'b0, 1);
    clr(); cp0_addr = 5'd13; ext_int_in = 6'd0;
    step("rst_cause", 32'h0, 1, 1'b0, 1);
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cp0_addr = 5'($urandom_range(0, 15));
      step("idle", 32'h0, 0, 1'b0, (i == 0));
    end
    cp0_addr = 5'd9;
    step("idle10_count", 32'd5, 1, 1'b0, 1);
    cp0_addr = 5'd12;
    step("idle10_status", 32'h0040_0000, 1, 1'b0, 1);

    // Timer interrupt on Count==Compare, cleared by a Compare write
    mtc0("cmp3", 5'd11, 32'd3);
    mtc0("status_8001", 5'd12, 32'h0000_8001);
    mtc0("count0", 5'd9, 32'd0);
    for (int i = 0; i < 10; i++) rd("timer_run", 5'd13);
    mtc0("cmp100", 5'd11, 32'd100);
    rd("timer_clr", 5'd13);
    rd("timer_clr2", 5'd13);

    // Address-error exception in a delay slot
    clr(); wb_ex = 1'b1; wb_excode = 5'h04; wb_bd = 1'b1;
    wb_pc = 32'hBFC0_0104; wb_badvaddr = 32'h0000_0003; cp0_addr = 5'd12;
    step("ex_adel", 32'h0, 0, 1'b0, 0);
    clr(); cp0_addr = 5'd14;
    step("ex_epc", 32'hBFC0_0100, 1, 1'b0, 1);
    rd_want("ex_badvaddr", 5'd8, 32'h0000_0003);
    rd("ex_cause", 5'd13);
    rd("ex_status", 5'd12);

    // Nested exception holds EPC/BD; ERET clears EXL
    clr(); wb_ex = 1'b1; wb_excode = 5'h0C; wb_bd = 1'b0;
    wb_pc = 32'h8000_0000; wb_badvaddr = 32'hFFFF_FFFF; cp0_addr = 5'd13;
    step("ex_nested", 32'h0, 0, 1'b0, 0);
    rd_want("nested_epc", 5'd14, 32'hBFC0_0100);
    rd("nested_cause", 5'd13);
    rd_want("nested_bad", 5'd8, 32'h0000_0003);
    clr(); eret_flush = 1'b1; mtc0_we = 1'b1; cp0_addr = 5'd12; mtc0_wdata = 32'h0000_FF03;
    step("eret_vs_mtc0", 32'h0, 0, 1'b0, 0);
    rd("eret_status", 5'd12);
    rd_want("eret_epc", 5'd14, 32'hBFC0_0100);

    // Exception beats same-cycle MTC0 to EPC
    clr(); wb_ex = 1'b1; wb_excode = 5'h08; wb_pc = 32'h8000_0010;
    mtc0_we = 1'b1; cp0_addr = 5'd14; mtc0_wdata = 32'h1234_5678;
    step("ex_vs_mtc0", 32'h0, 0, 1'b0, 0);
    rd_want("ex_vs_mtc0_epc", 5'd14, 32'h8000_0010);
    clr(); eret_flush = 1'b1;
    step("eret2", 32'h0, 0, 1'b0, 0);

    // BadVAddr read-only, unimplemented addresses read zero, no write bypass
    mtc0("bad_ro", 5'd8, 32'hCAFE_F00D);
    rd_want("bad_ro_rd", 5'd8, 32'h0000_0003);
    mtc0("unimpl_wr", 5'd20, 32'hFFFF_FFFF);
    rd_want("unimpl_rd", 5'd20, 32'h0);
    mtc0("sw_ip", 5'd13, 32'hFFFF_FFFF);
    rd("sw_ip_rd", 5'd13);
    mtc0("epc_wr", 5'd14, 32'hA5A5_0000);
    rd("epc_rd", 5'd14);

    // External interrupt lines
    mtc0("status_0401", 5'd12, 32'h0000_0401);
    ext_int_in = 6'b000100;
    rd("ext_ip4", 5'd13);
    rd("ext_ip4b", 5'd13);
    mtc0("status_1001", 5'd12, 32'h0000_1001);
    rd("ext_im4", 5'd13);
    ext_int_in = 6'b000000;
    rd("ext_drop", 5'd13);
    rd("ext_drop2", 5'd13);
    ext_int_in = 6'b000001;
    mtc0("status_0401b", 5'd12, 32'h0000_0401);
    rd("ext_ip2", 5'd13);
    ext_int_in = 6'd0;

    // Randomized commits
    for (int i = 0; i < 3000; i++) begin
      clr();
      resetn      = ($urandom_range(0, 199) != 0);
      wb_ex       = ($urandom_range(0, 9) == 0);
      wb_excode   = ($urandom_range(0, 2) == 0) ? 5'(4 + $urandom_range(0, 1))
                                                 : 5'($urandom_range(0, 31));
      wb_bd       = 1'($urandom_range(0, 1));
      wb_pc       = $urandom;
      wb_badvaddr = $urandom;
      eret_flush  = ($urandom_range(0, 9) == 0);
      mtc0_we     = ($urandom_range(0, 3) == 0);
      cp0_addr    = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 31))
                                                : impl_addr[$urandom_range(0, 5)];
      mtc0_wdata  = $urandom;
      if (cp0_addr == 5'd11 && $urandom_range(0, 1) == 1)
        mtc0_wdata = m_count + 32'($urandom_range(1, 6));
      if (cp0_addr == 5'd9 && $urandom_range(0, 3) == 0)
        mtc0_wdata = 32'hFFFF_FFFF - 32'($urandom_range(0, 4));
      if (cp0_addr == 5'd12 && $urandom_range(0, 1) == 1)
        mtc0_wdata = mtc0_wdata & 32'hFFFF_FFFD;
      if ($urandom_range(0, 7) == 0) ext_int_in = 6'($urandom_range(0, 63));
      step("rand", 32'h0, 0, 1'b0, 0);
    end

    clr(); resetn = 1'b1;
    for (int k = 0; k < 4 && sb.size() > 0; k++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
